fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of InstrMem: owns the program counter and drives the

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_buf.sv | 105 ++++++++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and types.
// Also holds the buffer credit check used by the PC issue logic.
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 1;

    localparam logic [ADDR_W-1:0]  RESET_PC  = '0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hA800_0000;

    // Occupancy of the 2-entry fetch buffer (0..2).
    typedef logic [1:0] fb_cnt_t;

    // True when one more read can be issued without the buffer
    // ever having to drop a returning word: buffered words plus
    // the word already in flight, minus this cycle's pop, must
    // leave a free slot.
    function automatic logic fb_credit_ok(
        input fb_cnt_t count,
        input logic    inflight,
        input logic    pop
    );
        logic [2:0] used;
        used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return used < 3'd2;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
// Ports: clk, rst_n, flush_i, push_i/push_pc_i/push_instr_i (write),
//        pop_i (consume head), valid_o/pc_o/instr_o (head), count_o.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int AW = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic [IW-1:0] push_instr_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [AW-1:0] pc_o,
    output logic [IW-1:0] instr_o,
    output fb_cnt_t       count_o
);

    logic [AW-1:0] head_pc_q, head_pc_d;
    logic [IW-1:0] head_instr_q, head_instr_d;
    logic [AW-1:0] tail_pc_q, tail_pc_d;
    logic [IW-1:0] tail_instr_q, tail_instr_d;
    fb_cnt_t       count_q, count_d;
    logic          do_pop;

    assign do_pop = pop_i & (count_q != 2'd0);

    // The head lives in a fixed register so that, once the buffer
    // drains, decode still sees the last word and its pc.
    always_comb begin
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        count_d      = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push_i) begin
                        head_pc_d    = push_pc_i;
                        head_instr_d = push_instr_i;
                        count_d      = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && do_pop) begin
                        head_pc_d    = push_pc_i;
                        head_instr_d = push_instr_i;
                    end else if (push_i) begin
                        tail_pc_d    = push_pc_i;
                        tail_instr_d = push_instr_i;
                        count_d      = 2'd2;
                    end else if (do_pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    // A push while full without a pop cannot occur:
                    // the issue credit rule reserves a slot first.
                    if (do_pop) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        if (push_i) begin
                            tail_pc_d    = push_pc_i;
                            tail_instr_d = push_instr_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
            count_q      <= 2'd0;
        end else begin
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            count_q      <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign pc_o    = head_pc_q;
    assign instr_o = head_instr_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives InstrMem, buffers
// returned words and hands them to decode over valid/ready.
// Ports: clk, rst_n, imem_addr/imem_instr (InstrMem),
//        redirect_valid/redirect_pc (taken branch from execute),
//        out_valid/out_instr/out_pc/out_ready (decode handshake).
module fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(fetch_pkg::PC_STEP)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    import fetch_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issued_pc_q;
    logic              inflight_q;
    logic              pop;
    logic              issue;
    logic              push;
    fb_cnt_t           count;

    // InstrMem reads every cycle; only cycles with issue=1 are
    // treated as real fetches.
    assign imem_addr = pc_q;

    assign pop   = out_valid & out_ready;
    assign issue = ~redirect_valid & fb_credit_ok(count, inflight_q, pop);

    // A word returning during a redirect belongs to the old path.
    assign push = inflight_q & ~redirect_valid;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_valid: pc_d = redirect_pc;
            issue:          pc_d = pc_q + PC_STEP;
            default:        pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                issued_pc_q <= pc_q;
            end
        end
    end

    fetch_buf #(
        .AW (ADDR_W),
        .IW (INSTR_W)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (issued_pc_q),
        .push_instr_i (imem_instr),
        .pop_i        (pop),
        .valid_o      (out_valid),
        .pc_o         (out_pc),
        .instr_o      (out_instr),
        .count_o      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a 256-word InstrMem model.
// Accepted words are scored against an expected-order queue.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    logic [31:0] imem_addr6;
    logic [31:0] imem_instr6;
    logic        redirect_valid6;
    logic [31:0] redirect_pc6;
    logic        out_valid6;
    logic [31:0] out_instr6;
    logic [31:0] out_pc6;
    logic        out_ready6;

    logic [31:0] mem [256];
    exp_t        expq[$];
    int          n_chk;
    int          n_pass;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFE)
    ) dut6 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr6),
        .imem_instr     (imem_instr6),
        .redirect_valid (redirect_valid6),
        .redirect_pc    (redirect_pc6),
        .out_valid      (out_valid6),
        .out_instr      (out_instr6),
        .out_pc         (out_pc6),
        .out_ready      (out_ready6)
    );

    function automatic logic [31:0] imem_word(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h2200_0005;
            8'd1:    return 32'h2440_0003;
            8'd2:    return 32'hA800_0000;
            8'd3:    return 32'hA000_FFFD;
            8'd4:    return 32'hA800_0000;
            default: return 32'h5A00_0000 | {24'h0, a};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = imem_word(8'(i));
        end
    end

    always @(posedge clk) begin
        imem_instr  <= mem[imem_addr[7:0]];
        imem_instr6 <= mem[imem_addr6[7:0]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = base + 32'(i);
            expq.push_back('{p, imem_word(p[7:0])});
        end
    endtask

    // Called at the negedge: scores the word decode accepts at the
    // coming posedge. A pop during a redirect is discarded.
    task automatic score();
        exp_t e;
        if (out_valid && out_ready && !redirect_valid) begin
            if (expq.size() == 0) begin
                chk("sb_unexpected_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("sb_pc", 64'(out_pc), 64'(e.pc));
                chk("sb_instr", 64'(out_instr), 64'(e.instr));
            end
        end
    endtask

    task automatic end_cycle();
        score();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after a posedge; drops reset between edges.
    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_addr6", 64'(imem_addr6), 64'hFFFF_FFFE);
        expq.delete();
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Release reset with out_ready=1 and expect pc 0.. with no gaps.
    task automatic stream(input string tag, input int n);
        push_seq(32'h0, n);
        out_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 64'(out_valid), (c >= 2) ? 64'd1 : 64'd0);
            end_cycle();
        end
        chk({tag, "_drain"}, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        bit hit;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        redirect_valid6 = 1'b0;
        redirect_pc6 = '0;
        out_ready6 = 1'b1;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("por_valid", 64'(out_valid), 64'd0);
        chk("por_pc", 64'(out_pc), 64'd0);
        chk("por_instr", 64'(out_instr), 64'd0);
        chk("por_addr", 64'(imem_addr), 64'd0);
        chk("por_addr6", 64'(imem_addr6), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;

        // Test 1: reset release latency and full throughput.
        stream("t1", 8);

        // Test 2: backpressure from cycle 0 through cycle 7.
        assert_reset();
        out_ready = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 2) begin
                chk("t2_valid_lo", 64'(out_valid), 64'd0);
            end else begin
                chk("t2_valid", 64'(out_valid), 64'd1);
                chk("t2_head_pc", 64'(out_pc), 64'd0);
                chk("t2_head_instr", 64'(out_instr), 64'h2200_0005);
                chk("t2_pc_stop", 64'(imem_addr), 64'd2);
            end
            if (c >= 3) begin
                chk("t2_count", 64'(dut.u_buf.count_o), 64'd2);
            end
            end_cycle();
        end
        out_ready = 1'b1;
        push_seq(32'h0, 6);

        // Test 3: redirect to 0 while pc 3 is at the head.
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            chk("t2_nogap", 64'(out_valid), 64'd1);
            if (out_valid && out_pc == 32'd3) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0;
                hit = 1'b1;
            end
            end_cycle();
            redirect_valid = 1'b0;
        end
        chk("t3_found_pc3", 64'(hit), 64'd1);
        expq.delete();
        push_seq(32'h0, 4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t3_valid", 64'(out_valid), (c >= 3) ? 64'd1 : 64'd0);
            end_cycle();
        end
        chk("t3_drain", 64'(expq.size()), 64'd0);

        // Test 4: redirect with a full buffer and out_ready=1.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("t4_full", 64'(dut.u_buf.count_o), 64'd2);
            end
            end_cycle();
        end
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        push_seq(32'h20, 4);
        @(negedge clk);
        end_cycle();
        redirect_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("t4_empty", 64'(dut.u_buf.count_o), 64'd0);
            end
            chk("t4_valid", 64'(out_valid), (c >= 3) ? 64'd1 : 64'd0);
            end_cycle();
        end
        chk("t4_drain", 64'(expq.size()), 64'd0);

        // Test 5: asynchronous reset mid-stream, then restart.
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        assert_reset();
        stream("t5", 6);

        // Test 6: RESET_PC near the top of the address space.
        out_ready = 1'b0;
        assert_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [31:0] ep;
            @(negedge clk);
            chk("t6_valid", 64'(out_valid6), (c >= 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                ep = 32'hFFFF_FFFE + 32'(c - 2);
                chk("t6_pc", 64'(out_pc6), 64'(ep));
                chk("t6_instr", 64'(out_instr6), 64'(imem_word(ep[7:0])));
            end
            end_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
